// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common data bus.
package cdb_pkg;

    localparam int DEF_TAG_W  = 6;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
    } cdb_entry_t;

    function automatic int src_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO; any depth, wrapping pointers.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = cdb_entry_t
) (
    input  logic   clk,
    input  logic   clear,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push) wr_d = nxt(wr_q);
        if (pop)  rd_d = nxt(rd_q);
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign head  = mem_q[rd_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-lane round-robin common data bus with per-source buffering.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int NUM_LANES  = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_WIDTH  = DEF_TAG_W,
    parameter int DATA_WIDTH = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic [NUM_LANES-1:0]    cdb_valid,
    output logic [NUM_LANES*TAG_WIDTH-1:0]  cdb_tag,
    output logic [NUM_LANES*DATA_WIDTH-1:0] cdb_data,
    output logic [NUM_LANES*$clog2(NUM_SRC)-1:0] cdb_src,
    output logic [15:0]             conflict_cnt
);

    localparam int SIW = src_idx_w(NUM_SRC);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t             din  [NUM_SRC];
    entry_t             head [NUM_SRC];
    logic [NUM_SRC-1:0] full, empty, push, grant, avail;
    logic [SIW-1:0]     rr_q, rr_d, sel, last_idx;
    logic [15:0]        cc_q, cc_d;
    logic               kill, found;

    assign kill = rst | flush;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign din[g].tag  = src_tag[g*TAG_WIDTH +: TAG_WIDTH];
        assign din[g].data = src_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign push[g]     = src_valid[g] & ~full[g] & ~kill;

        cdb_src_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk   (clk),
            .clear (kill),
            .push  (push[g]),
            .pop   (grant[g]),
            .din   (din[g]),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign src_ready = ~full;

    // Each lane takes the first still-unclaimed head in cyclic order from rr.
    always_comb begin
        grant     = '0;
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_data  = '0;
        cdb_src   = '0;
        last_idx  = rr_q;
        sel       = '0;
        found     = 1'b0;
        avail     = kill ? '0 : ~empty;
        for (int k = 0; k < NUM_LANES; k++) begin
            found = 1'b0;
            for (int j = 0; j < NUM_SRC; j++) begin
                sel = SIW'((int'(rr_q) + j) % NUM_SRC);
                if (!found && avail[sel]) begin
                    found        = 1'b1;
                    avail[sel]   = 1'b0;
                    grant[sel]   = 1'b1;
                    last_idx     = sel;
                    cdb_valid[k] = 1'b1;
                    cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]    = head[sel].tag;
                    cdb_data[k*DATA_WIDTH +: DATA_WIDTH] = head[sel].data;
                    cdb_src[k*SIW +: SIW] = sel;
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (|grant) begin
            rr_d = (last_idx == SIW'(NUM_SRC - 1)) ? '0
                 : last_idx + SIW'(1);
        end
        cc_d = cc_q;
        if (!flush && ($countones(~empty) > NUM_LANES)
            && (cc_q != 16'hFFFF)) begin
            cc_d = cc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            cc_q <= '0;
        end else begin
            rr_q <= flush ? '0 : rr_d;
            cc_q <= cc_d;
        end
    end

    assign conflict_cnt = cc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus reset and dual-lane sequences.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   src_valid;
    logic [23:0]  src_tag;
    logic [127:0] src_data;

    logic [3:0]   src_ready;
    logic [0:0]   cdb_valid;
    logic [5:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;
    logic [15:0]  cc;

    logic [3:0]   rdy2;
    logic [1:0]   v2;
    logic [11:0]  tag2;
    logic [63:0]  data2;
    logic [3:0]   src2;
    logic [15:0]  cc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_SRC(4), .NUM_LANES(1), .FIFO_DEPTH(2),
        .TAG_WIDTH(6), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag),
        .src_data(src_data), .src_ready(src_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src),
        .conflict_cnt(cc)
    );

    cdb_arbiter #(
        .NUM_SRC(4), .NUM_LANES(2), .FIFO_DEPTH(2),
        .TAG_WIDTH(6), .DATA_WIDTH(32)
    ) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag),
        .src_data(src_data), .src_ready(rdy2),
        .cdb_valid(v2), .cdb_tag(tag2),
        .cdb_data(data2), .cdb_src(src2),
        .conflict_cnt(cc2)
    );

    typedef struct {
        logic [3:0]      vld;
        logic            fl;
        logic [3:0][5:0] tg;
        logic            ev;
        logic [1:0]      es;
        logic [5:0]      et;
        logic [3:0]      er;
        logic [15:0]     ec;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] dfun(input logic [5:0] t);
        return {t, t ^ 6'h2A, 20'hC0FFE};
    endfunction

    function automatic vec_t mk(
        input logic [3:0] vld, input logic fl,
        input logic [5:0] t0, input logic [5:0] t1,
        input logic [5:0] t2, input logic [5:0] t3,
        input logic ev, input logic [1:0] es,
        input logic [5:0] et, input logic [3:0] er,
        input logic [15:0] ec);
        vec_t v;
        v.vld = vld; v.fl = fl;
        v.tg[0] = t0; v.tg[1] = t1;
        v.tg[2] = t2; v.tg[3] = t3;
        v.ev = ev; v.es = es; v.et = et;
        v.er = er; v.ec = ec;
        return v;
    endfunction

    task automatic drive(input logic [3:0] vld, input logic fl,
                         input logic [3:0][5:0] tg);
        src_valid = vld;
        flush     = fl;
        for (int i = 0; i < 4; i++) begin
            src_tag[i*6 +: 6]   = tg[i];
            src_data[i*32 +: 32] = dfun(tg[i]);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [3:0][5:0] tz;
        logic [3:0][5:0] tt;
        tz = '0;

        // vld, fl, t0..t3, ev, es, et, ready, cc
        tbl.push_back(mk(4'b0100,0,0,0,6'h01,0, 0,0,0,     4'b1111,0));
        tbl.push_back(mk(4'b0100,0,0,0,6'h02,0, 1,2,6'h01, 4'b1111,0));
        tbl.push_back(mk(4'b0100,0,0,0,6'h03,0, 1,2,6'h02, 4'b1111,0));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,2,6'h03, 4'b1111,0));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     0,0,0,     4'b1111,0));
        tbl.push_back(mk(4'b1111,0,6'h10,6'h11,6'h12,6'h13,
                         0,0,0,     4'b1111,0));
        tbl.push_back(mk(4'b1111,0,6'h18,6'h19,6'h1A,6'h1B,
                         1,3,6'h13, 4'b1111,0));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,0,6'h10, 4'b1000,1));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,1,6'h11, 4'b1001,2));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,2,6'h12, 4'b1011,3));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,3,6'h1B, 4'b1111,4));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,0,6'h18, 4'b1111,5));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,1,6'h19, 4'b1111,6));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,2,6'h1A, 4'b1111,7));
        tbl.push_back(mk(4'b1111,0,6'h2F,6'h30,6'h31,6'h32,
                         0,0,0,     4'b1111,7));
        tbl.push_back(mk(4'b0110,0,0,6'h33,6'h34,0,
                         1,3,6'h32, 4'b1111,7));
        tbl.push_back(mk(4'b0001,0,6'h20,0,0,0, 1,0,6'h2F, 4'b1001,8));
        tbl.push_back(mk(4'b0001,0,6'h21,0,0,0, 1,1,6'h30, 4'b1001,9));
        tbl.push_back(mk(4'b0001,0,6'h22,0,0,0, 1,2,6'h31, 4'b1010,10));
        tbl.push_back(mk(4'b0001,0,6'h22,0,0,0, 1,0,6'h20, 4'b1110,11));
        tbl.push_back(mk(4'b0001,0,6'h22,0,0,0, 1,1,6'h33, 4'b1111,12));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,2,6'h34, 4'b1110,13));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,0,6'h21, 4'b1110,14));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,0,6'h22, 4'b1111,14));
        tbl.push_back(mk(4'b1101,0,6'h40,0,6'h41,6'h42,
                         0,0,0,     4'b1111,14));
        tbl.push_back(mk(4'b0010,1,0,6'h43,0,0, 0,0,0,     4'b1111,14));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     0,0,0,     4'b1111,14));
        tbl.push_back(mk(4'b1001,0,6'h50,0,0,6'h51,
                         0,0,0,     4'b1111,14));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,0,6'h50, 4'b1111,14));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     1,3,6'h51, 4'b1111,15));
        tbl.push_back(mk(4'b0000,0,0,0,0,0,     0,0,0,     4'b1111,15));

        // Reset held two cycles with every producer offering.
        tt[0] = 6'h3A; tt[1] = 6'h3B; tt[2] = 6'h3C; tt[3] = 6'h3D;
        rst = 1'b1;
        drive(4'b1111, 1'b0, tt);
        #1;
        chk("rst c0 valid", 64'(cdb_valid), 64'd0);
        @(negedge clk); #1;
        chk("rst c1 valid", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 1'b0, tz);
        #1;
        chk("rst ready", 64'(src_ready), 64'hF);
        chk("rst cc", 64'(cc), 64'd0);
        chk("rst valid", 64'(cdb_valid), 64'd0);
        chk("rst tag", 64'(cdb_tag), 64'd0);
        chk("rst src", 64'(cdb_src), 64'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].fl, tbl[i].tg);
            #1;
            chk($sformatf("v%0d valid", i), 64'(cdb_valid),
                64'(tbl[i].ev));
            chk($sformatf("v%0d src", i), 64'(cdb_src),
                64'(tbl[i].es));
            chk($sformatf("v%0d tag", i), 64'(cdb_tag),
                64'(tbl[i].et));
            chk($sformatf("v%0d data", i), 64'(cdb_data),
                tbl[i].ev ? 64'(dfun(tbl[i].et)) : 64'd0);
            chk($sformatf("v%0d ready", i), 64'(src_ready),
                64'(tbl[i].er));
            chk($sformatf("v%0d cc", i), 64'(cc), 64'(tbl[i].ec));
        end

        // Reset in the middle of traffic also clears the conflict counter.
        @(negedge clk);
        tt[0] = 6'h01; tt[1] = 6'h02; tt[2] = 6'h03; tt[3] = 6'h04;
        drive(4'b1111, 1'b0, tt);
        @(negedge clk);
        drive(4'b0000, 1'b0, tz);
        #1;
        chk("mid valid", 64'(cdb_valid), 64'd1);
        chk("mid tag", 64'(cdb_tag), 64'h01);
        chk("mid cc", 64'(cc), 64'd15);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst valid", 64'(cdb_valid), 64'd0);
        chk("mid rst v2", 64'(v2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post rst cc", 64'(cc), 64'd0);
        chk("post rst cc2", 64'(cc2), 64'd0);
        chk("post rst ready", 64'(src_ready), 64'hF);
        chk("post rst valid", 64'(cdb_valid), 64'd0);

        // Dual lane: steer rr to 3, then sources 1 and 3 compete.
        @(negedge clk);
        tt = '0; tt[2] = 6'h05;
        drive(4'b0100, 1'b0, tt);
        #1;
        chk("d0 v2", 64'(v2), 64'd0);
        @(negedge clk);
        drive(4'b0000, 1'b0, tz);
        #1;
        chk("d1 v2", 64'(v2), 64'b01);
        chk("d1 src2", 64'(src2), 64'b0010);
        chk("d1 tag2", 64'(tag2), 64'h005);
        chk("d1 data2", 64'(data2), {32'd0, dfun(6'h05)});
        @(negedge clk);
        tt = '0; tt[1] = 6'h07; tt[3] = 6'h09;
        drive(4'b1010, 1'b0, tt);
        #1;
        chk("d2 v2", 64'(v2), 64'd0);
        @(negedge clk);
        drive(4'b0000, 1'b0, tz);
        #1;
        chk("d3 v2", 64'(v2), 64'b11);
        chk("d3 src2", 64'(src2), 64'b0111);
        chk("d3 tag2", 64'(tag2), {52'd0, 6'h07, 6'h09});
        chk("d3 data2", 64'(data2), {dfun(6'h07), dfun(6'h09)});
        @(negedge clk);
        tt[0] = 6'h0D; tt[1] = 6'h0A; tt[2] = 6'h0B; tt[3] = 6'h0C;
        drive(4'b1111, 1'b0, tt);
        #1;
        chk("d4 v2", 64'(v2), 64'd0);
        @(negedge clk);
        drive(4'b0000, 1'b0, tz);
        #1;
        chk("d5 v2", 64'(v2), 64'b11);
        chk("d5 src2", 64'(src2), 64'b1110);
        chk("d5 tag2", 64'(tag2), {52'd0, 6'h0C, 6'h0B});
        @(negedge clk); #1;
        chk("d6 v2", 64'(v2), 64'b11);
        chk("d6 src2", 64'(src2), 64'b0100);
        chk("d6 tag2", 64'(tag2), {52'd0, 6'h0A, 6'h0D});
        @(negedge clk); #1;
        chk("d7 v2", 64'(v2), 64'd0);
        chk("d7 cc2", 64'(cc2), 64'd1);
        chk("d7 rdy2", 64'(rdy2), 64'hF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
